// File: rtl/fetch_realigner_if.sv
// Fetch-side and queue-side signal bundle for fetch_realigner.
// master: fetch source / instruction queue side; slave: the realigner.
interface fetch_realigner_if #(
  parameter int INST_PER_FETCH = 2,
  parameter int ADDR_W         = 32
);
  logic                             flush;
  logic                             fetch_valid;
  logic                             fetch_ready;
  logic [ADDR_W-1:0]                fetch_addr;
  logic [31:0]                      fetch_data;
  logic [INST_PER_FETCH-1:0]        out_valid;
  logic [INST_PER_FETCH*ADDR_W-1:0] out_pc;
  logic [INST_PER_FETCH*32-1:0]     out_inst;
  logic [INST_PER_FETCH-1:0]        out_is_compressed;
  logic                             out_ready;
  logic                             straddle;

  modport master (
    output flush, fetch_valid, fetch_addr, fetch_data, out_ready,
    input  fetch_ready, out_valid, out_pc, out_inst, out_is_compressed, straddle
  );

  modport slave (
    input  flush, fetch_valid, fetch_addr, fetch_data, out_ready,
    output fetch_ready, out_valid, out_pc, out_inst, out_is_compressed, straddle
  );
endinterface

// File: rtl/fetch_realigner.sv
// fetch_realigner: splits 32-bit fetch words into up to two PC-tagged
// RISC-V instructions for the instruction queue. Outputs are combinational
// from the presented word and the pending-half state (zero added latency).
//
// Build option FETCH_REALIGNER_RVC_EN:
//   defined   - full RVC realignment: compressed instructions, 32-bit
//               instructions straddling two words, halfword branch targets.
//   undefined - each accepted word-aligned fetch is one 32-bit instruction
//               in lane0; halfword-aligned fetches emit nothing.
module fetch_realigner #(
  parameter int INST_PER_FETCH = 2,
  parameter int ADDR_W         = 32
) (
  input  logic               clock,
  input  logic               reset,
  fetch_realigner_if.slave   bus
);

  logic              emit_en;
  logic              accept;
  logic              lane0_vld;
  logic              lane1_vld;
  logic [31:0]       lane0_inst;
  logic [31:0]       lane1_inst;
  logic [ADDR_W-1:0] lane0_pc;
  logic [ADDR_W-1:0] lane1_pc;
  logic              lane0_c;
  logic              lane1_c;
  logic              lane0_strad;

  // The queue must take two instructions whenever a word is taken, so the
  // fetch side simply follows the queue's readiness.
  assign bus.fetch_ready = bus.out_ready & ~reset;
  assign emit_en         = bus.fetch_valid & bus.out_ready & ~bus.flush & ~reset;
  assign accept          = bus.fetch_valid & bus.fetch_ready & ~bus.flush;

`ifdef FETCH_REALIGNER_RVC_EN

  logic              pend_valid_q;
  logic              pend_valid_d;
  logic [15:0]       pend_half_q;
  logic [15:0]       pend_half_d;
  logic [ADDR_W-1:0] pend_pc_q;
  logic [ADDR_W-1:0] pend_pc_d;

  logic [15:0]       lo_half;
  logic [15:0]       hi_half;
  logic [ADDR_W-1:0] addr_p2;
  logic              use_pend;
  logic              upper_step;
  logic              word_pend_valid;
  logic [15:0]       word_pend_half;
  logic [ADDR_W-1:0] word_pend_pc;

  // A halfword starts a compressed instruction unless its two LSBs are 11.
  function automatic logic is_rvc(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction

  assign lo_half  = bus.fetch_data[15:0];
  assign hi_half  = bus.fetch_data[31:16];
  assign addr_p2  = bus.fetch_addr + ADDR_W'(2);
  // The saved half only belongs to this word if the stream is contiguous.
  assign use_pend = pend_valid_q & (bus.fetch_addr == (pend_pc_q + ADDR_W'(2)));

  // Decode the presented word into lanes and the half left over for next time.
  always_comb begin
    lane0_vld       = 1'b0;
    lane1_vld       = 1'b0;
    lane0_inst      = 32'h0;
    lane1_inst      = 32'h0;
    lane0_pc        = '0;
    lane1_pc        = '0;
    lane0_c         = 1'b0;
    lane1_c         = 1'b0;
    lane0_strad     = 1'b0;
    upper_step      = 1'b0;
    word_pend_valid = 1'b0;
    word_pend_half  = pend_half_q;
    word_pend_pc    = pend_pc_q;

    if (bus.fetch_addr[1]) begin
      // Halfword-aligned target: the low half precedes the target and is ignored.
      if (is_rvc(hi_half[1:0])) begin
        lane0_vld  = 1'b1;
        lane0_inst = {16'h0, hi_half};
        lane0_pc   = bus.fetch_addr;
        lane0_c    = 1'b1;
      end else begin
        word_pend_valid = 1'b1;
        word_pend_half  = hi_half;
        word_pend_pc    = bus.fetch_addr;
      end
    end else begin
      lane0_vld  = 1'b1;
      upper_step = 1'b1;
      if (use_pend) begin
        // Saved upper half of the previous word plus this low half.
        lane0_inst  = {lo_half, pend_half_q};
        lane0_pc    = pend_pc_q;
        lane0_strad = 1'b1;
      end else if (is_rvc(lo_half[1:0])) begin
        lane0_inst = {16'h0, lo_half};
        lane0_pc   = bus.fetch_addr;
        lane0_c    = 1'b1;
      end else begin
        // Aligned 32-bit instruction consumes the whole word.
        lane0_inst = bus.fetch_data;
        lane0_pc   = bus.fetch_addr;
        upper_step = 1'b0;
      end

      if (upper_step) begin
        if (is_rvc(hi_half[1:0])) begin
          lane1_vld  = 1'b1;
          lane1_inst = {16'h0, hi_half};
          lane1_pc   = addr_p2;
          lane1_c    = 1'b1;
        end else begin
          word_pend_valid = 1'b1;
          word_pend_half  = hi_half;
          word_pend_pc    = addr_p2;
        end
      end
    end
  end

  // Pending-half next state: flush wins, otherwise update only on an accepted word.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_half_d  = pend_half_q;
    pend_pc_d    = pend_pc_q;
    if (bus.flush) begin
      pend_valid_d = 1'b0;
    end else if (accept) begin
      pend_valid_d = word_pend_valid;
      pend_half_d  = word_pend_half;
      pend_pc_d    = word_pend_pc;
    end
  end

  // Pending-half registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_half_q  <= 16'h0;
      pend_pc_q    <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_half_q  <= pend_half_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

`else

  // Only the pending flag exists in this build; it never sets, so every word
  // is decoded on its own.
  logic pend_valid_q;
  logic pend_valid_d;

  // Whole word becomes one 32-bit instruction; halfword-aligned fetches are dropped.
  always_comb begin
    lane0_vld    = ~bus.fetch_addr[1] & ~pend_valid_q;
    lane1_vld    = 1'b0;
    lane0_inst   = bus.fetch_data;
    lane1_inst   = 32'h0;
    lane0_pc     = bus.fetch_addr;
    lane1_pc     = '0;
    lane0_c      = 1'b0;
    lane1_c      = 1'b0;
    lane0_strad  = 1'b0;
    pend_valid_d = 1'b0;
  end

  // Pending flag register, held at its reset value.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
    end
  end

`endif

  assign bus.out_valid         = {lane1_vld & emit_en, lane0_vld & emit_en};
  assign bus.out_pc            = {lane1_pc, lane0_pc};
  assign bus.out_inst          = {lane1_inst, lane0_inst};
  assign bus.out_is_compressed = {lane1_c, lane0_c};
  assign bus.straddle          = lane0_strad & lane0_vld & emit_en;

endmodule
